// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared widths and types for the data-memory arbiter
package dmem_arbiter_pkg;
  localparam int DATA_ADDRESS_WIDTH = 6;
  localparam int CPU_DATA_WIDTH = 32;
  localparam int BE_WIDTH = CPU_DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, CPU, DBG} arb_owner_t;
  typedef struct packed {
    logic we;
    logic [DATA_ADDRESS_WIDTH-1:0] addr;
    logic [CPU_DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0] be;
  } mem_req_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, debug and memory-side signals of the data-memory arbiter
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;
  logic cpu_req, cpu_we, dbg_req, dbg_we, dbg_prio;
  logic [DATA_ADDRESS_WIDTH-1:0] cpu_addr, dbg_addr;
  logic [CPU_DATA_WIDTH-1:0] cpu_wdata, dbg_wdata;
  logic [BE_WIDTH-1:0] cpu_be, dbg_be;
  logic cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_stall;
  logic [CPU_DATA_WIDTH-1:0] cpu_rdata, dbg_rdata;
  logic mem_en, mem_we;
  logic [DATA_ADDRESS_WIDTH-1:0] mem_addr;
  logic [CPU_DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  logic [BE_WIDTH-1:0] mem_be;
  arb_owner_t owner;
  modport slave (
    input cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be, dbg_prio, mem_rdata,
    output cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, cpu_stall,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be, owner
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be, dbg_prio, mem_rdata,
    input cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, cpu_stall,
    input mem_en, mem_we, mem_addr, mem_wdata, mem_be, owner
  );
endinterface

// File: rtl/dmem_resp_tracker.sv
// dmem_resp_tracker: remembers which port issued a read and flags its rvalid one cycle later
module dmem_resp_tracker
  import dmem_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_gnt_i,
  input  arb_owner_t                rd_owner_i,
  input  logic [CPU_DATA_WIDTH-1:0] mem_rdata_i,
  output logic                      cpu_rvalid_o,
  output logic                      dbg_rvalid_o,
  output logic [CPU_DATA_WIDTH-1:0] cpu_rdata_o,
  output logic [CPU_DATA_WIDTH-1:0] dbg_rdata_o
);
  logic pending_q;
  arb_owner_t owner_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      owner_q <= IDLE;
    end else begin
      pending_q <= rd_gnt_i;
      owner_q <= rd_gnt_i ? rd_owner_i : IDLE;
    end
  end
  always_comb begin
    cpu_rvalid_o = pending_q & (owner_q == CPU);
    dbg_rvalid_o = pending_q & (owner_q == DBG);
    cpu_rdata_o = mem_rdata_i;
    dbg_rdata_o = mem_rdata_i;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU and a debug port with a starvation guard
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter logic [3:0] STARVE_LIMIT = 4'd4
) (
  input logic         clk,
  input logic         rst_n,
  dmem_arbiter_if.slave bus
);
  arb_owner_t owner_q, owner_d, gnt_owner;
  logic [3:0] starve_q, starve_d;
  logic cpu_gnt, dbg_gnt, starved, mem_en;
  mem_req_t cpu_r, dbg_r, req;
  always_comb begin
    cpu_r = {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata, bus.cpu_be};
    dbg_r = {bus.dbg_we, bus.dbg_addr, bus.dbg_wdata, bus.dbg_be};
    starved = starve_q == STARVE_LIMIT;
    dbg_gnt = rst_n & bus.dbg_req & (bus.dbg_prio | starved | ~bus.cpu_req);
    cpu_gnt = rst_n & bus.cpu_req & ~dbg_gnt;
    mem_en = cpu_gnt | dbg_gnt;
    req = dbg_gnt ? dbg_r : cpu_r;
    gnt_owner = dbg_gnt ? DBG : CPU;
    owner_d = mem_en ? gnt_owner : owner_q;
    starve_d = (dbg_gnt | ~bus.dbg_req) ? 4'd0 : (cpu_gnt & ~starved) ? starve_q + 4'd1 : starve_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= IDLE;
      starve_q <= 4'd0;
    end else begin
      owner_q <= owner_d;
      starve_q <= starve_d;
    end
  end
  assign bus.cpu_gnt = cpu_gnt;
  assign bus.dbg_gnt = dbg_gnt;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;
  assign bus.mem_en = mem_en;
  assign bus.mem_we = mem_en & req.we;
  assign bus.mem_addr = req.addr;
  assign bus.mem_wdata = req.wdata;
  assign bus.mem_be = req.be;
  assign bus.owner = owner_q;
  dmem_resp_tracker u_trk (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_gnt_i     (mem_en & ~req.we),
    .rd_owner_i   (gnt_owner),
    .mem_rdata_i  (bus.mem_rdata),
    .cpu_rvalid_o (bus.cpu_rvalid),
    .dbg_rvalid_o (bus.dbg_rvalid),
    .cpu_rdata_o  (bus.cpu_rdata),
    .dbg_rdata_o  (bus.dbg_rdata)
  );
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port synchronous data memory inside `mem_stage` between the CPU load/store path and a debug/loader port. Lets a host preload or inspect data memory while the pipeline runs. The CPU normally has priority; a starvation counter guarantees debug progress. The arbiter also produces the CPU stall request consumed by the hazard unit.

## Interface
- `DATA_ADDRESS_WIDTH`, 6: word-address width of data memory (64 words).
- `CPU_DATA_WIDTH`, 32: data word width; byte-enable width is `CPU_DATA_WIDTH/8`.
- `STARVE_LIMIT`, 4: consecutive CPU wins over a waiting debug request before debug is forced through; legal range 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (`RESET` = 1'b0 in `common`).
- `cpu_req`, `dbg_req`  in  1  request valid; held with its payload until granted.
- `cpu_we`, `dbg_we`  in  1  1 = write, 0 = read.
- `cpu_addr`, `dbg_addr`  in  DATA_ADDRESS_WIDTH  word address.
- `cpu_wdata`, `dbg_wdata`  in  CPU_DATA_WIDTH  write data.
- `cpu_be`, `dbg_be`  in  CPU_DATA_WIDTH/8  byte enables (writes only).
- `dbg_prio`  in  1  debug gets absolute priority (CPU halted by debugger).
- `cpu_gnt`, `dbg_gnt`  out  1  request accepted this cycle.
- `cpu_rvalid`, `dbg_rvalid`  out  1  read data valid for that port.
- `cpu_rdata`, `dbg_rdata`  out  CPU_DATA_WIDTH  read data, qualified by rvalid.
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`.
- `mem_en`, `mem_we`  out  1  memory access / write strobe.
- `mem_addr`  out  DATA_ADDRESS_WIDTH; `mem_wdata`  out  CPU_DATA_WIDTH; `mem_be`  out  CPU_DATA_WIDTH/8.
- `mem_rdata`  in  CPU_DATA_WIDTH  memory read data, one cycle after `mem_en & ~mem_we`.

## Operation
- Owner FSM, states `IDLE`, `CPU`, `DBG` = last granted port; registered, used only for status and tie-break after forced debug grant.
- Grant decision each cycle, in order: `dbg_prio & dbg_req` -> debug; `dbg_req & starve_cnt == STARVE_LIMIT` -> debug; `cpu_req` -> CPU; `dbg_req` -> debug; else none.
- At most one grant per cycle; the loser's `gnt` = 0 and it holds its request.
- `starve_cnt` (4 bits): +1 when CPU granted while `dbg_req` = 1; cleared when debug granted or `dbg_req` = 0; saturates at `STARVE_LIMIT`.
- Granted port's payload is muxed onto `mem_*`; `mem_en` = any grant; `mem_we` = granted `we`.
- Response tracker: registers `{pending, owner}` when a read is granted; next cycle asserts owner's `rvalid`. `mem_rdata` is routed to both `*_rdata`; only the owner's rvalid is set.
- Writes produce no rvalid; write then read to the same address in consecutive cycles returns the new data (memory is write-first across cycles).

## Timing
- Grant: combinational, same cycle as request; memory access in that cycle.
- Read latency: `rvalid` exactly 1 cycle after `gnt`. Back-to-back reads on alternating ports return in grant order, one per cycle.
- Throughput: one access per cycle, no bubbles.
- Reset values: `cpu_gnt`/`dbg_gnt` 0 (combinational, forced 0 while in reset), both rvalid 0, rdata passes `mem_rdata`, FSM `IDLE`, `starve_cnt` 0, `pending` 0, `mem_en` 0.
- Reset mid-read: pending response discarded; no rvalid after reset release.
- Simultaneous requests with `dbg_prio` = 0: CPU wins until `starve_cnt` reaches limit, then exactly one debug grant, then CPU again.
- `dbg_prio` rising while CPU waits: CPU stalls indefinitely; no starvation guard for CPU.

## Structure
- `common` gains: `arb_owner_t` enum (`IDLE`, `CPU`, `DBG`), `mem_req_t` packed struct {we, addr, wdata, be}.
- One sub-module natural: `dmem_resp_tracker` (pending/owner register and rvalid routing).
- Instantiated in `mem_stage` between stage logic and `data_memory`; debug port tied off (req = 0) when unused.

## Test plan
- Reset: hold `rst` = 0 with both requests high -> no gnt, no rvalid, `mem_en` = 0; release -> CPU granted first cycle.
- Debug write addr 5 = 32'hDEADBEEF, be = 4'hF, then CPU read addr 5 -> `cpu_rvalid` 1 cycle after grant, `cpu_rdata` = 32'hDEADBEEF, `dbg_rvalid` stays 0.
- Both request continuously, `STARVE_LIMIT` = 4 -> grant sequence CPU,CPU,CPU,CPU,DBG repeating; `cpu_stall` high only in DBG cycles.
- `dbg_prio` = 1, both requesting for 6 cycles -> 6 debug grants, `cpu_stall` = 1 throughout.
- Byte write be = 4'b0010, wdata 32'h0000AB00 over 32'h11223344 at addr 63 -> read returns 32'h1122AB44.
- Assert reset in the cycle after a CPU read grant -> no `cpu_rvalid` after release; next request served normally.
